// File: rtl/rst_sequencer.sv
// Reset sequencer for the clocking subsystem: pulses the MMCM reset, waits for stable lock,
// then releases the tx, rx and sys domain resets in strict order, re-sequencing on lock loss.
module rst_sequencer #(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int STAGE_GAP_CYCLES    = 64,
  parameter int CNT_W               = 8
) (
  input  logic             clkIn,
  input  logic             rstNIn,
  input  logic             mmcm0LockedIn,
  input  logic             mmcm1LockedIn,
  input  logic             swRstIn,
  output logic             mmcmRstOut,
  output logic             rstTxOut,
  output logic             rstRxOut,
  output logic             rstSysOut,
  output logic             readyOut,
  output logic [CNT_W-1:0] retryCntOut,
  output logic [CNT_W-1:0] lockLossCntOut
);

  localparam int TMR_MAX0 = (MMCM_RST_CYCLES > STAGE_GAP_CYCLES) ? MMCM_RST_CYCLES : STAGE_GAP_CYCLES;
  localparam int TMR_MAX  = (LOCK_TIMEOUT_CYCLES > TMR_MAX0) ? LOCK_TIMEOUT_CYCLES : TMR_MAX0;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int STB_W    = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_ZERO     = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0] TMR_RST_LOAD = TMR_W'(MMCM_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_TO_LOAD  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_GAP_LOAD = TMR_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_ZERO     = {STB_W{1'b0}};
  localparam logic [STB_W-1:0] STB_ONE      = STB_W'(32'd1);
  localparam logic [STB_W-1:0] STB_LAST     = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    MMCM_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    REL_TX    = 3'd2,
    REL_RX    = 3'd3,
    REL_SYS   = 3'd4,
    RUN       = 3'd5
  } seqStateT;

  function automatic logic [TMR_W-1:0] reloadFor(input seqStateT s);
    case (s)
      MMCM_RST:               reloadFor = TMR_RST_LOAD;
      WAIT_LOCK:              reloadFor = TMR_TO_LOAD;
      REL_TX, REL_RX, REL_SYS: reloadFor = TMR_GAP_LOAD;
      default:                reloadFor = TMR_ZERO;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  logic             lock0Meta, lock0Sync, lock1Meta, lock1Sync;
  logic             lockOk;
  seqStateT         state, stateNext;
  logic [TMR_W-1:0] tmr, tmrNext;
  logic [STB_W-1:0] stableCnt, stableCntNext;
  logic [CNT_W-1:0] retryCnt, lossCnt;
  logic             retryInc, lossInc, abortReq;

  assign lockOk         = lock0Sync & lock1Sync;
  assign abortReq       = !lockOk || swRstIn;
  assign retryCntOut    = retryCnt;
  assign lockLossCntOut = lossCnt;

  // Two-flop synchronisers for the asynchronous MMCM lock inputs.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      lock0Meta <= 1'b0;
      lock0Sync <= 1'b0;
      lock1Meta <= 1'b0;
      lock1Sync <= 1'b0;
    end else begin
      lock0Meta <= mmcm0LockedIn;
      lock0Sync <= lock0Meta;
      lock1Meta <= mmcm1LockedIn;
      lock1Sync <= lock1Meta;
    end
  end

  // Next-state, shared timer and stable-lock counter decode.
  always_comb begin
    stateNext     = state;
    retryInc      = 1'b0;
    lossInc       = 1'b0;
    tmrNext       = tmr;
    stableCntNext = STB_ZERO;
    case (state)
      MMCM_RST: begin
        if (tmr == TMR_ZERO) stateNext = WAIT_LOCK;
        else                 stateNext = MMCM_RST;
      end
      WAIT_LOCK: begin
        // Stable lock takes priority over a timeout expiring on the same cycle.
        if (swRstIn) begin
          stateNext = MMCM_RST;
        end else if (lockOk && (stableCnt == STB_LAST)) begin
          stateNext = REL_TX;
        end else if (tmr == TMR_ZERO) begin
          stateNext = MMCM_RST;
          retryInc  = 1'b1;
        end else begin
          stateNext = WAIT_LOCK;
        end
      end
      REL_TX: begin
        if (abortReq)              stateNext = MMCM_RST;
        else if (tmr == TMR_ZERO)  stateNext = REL_RX;
        else                       stateNext = REL_TX;
      end
      REL_RX: begin
        if (abortReq)              stateNext = MMCM_RST;
        else if (tmr == TMR_ZERO)  stateNext = REL_SYS;
        else                       stateNext = REL_RX;
      end
      REL_SYS: begin
        if (abortReq)              stateNext = MMCM_RST;
        else if (tmr == TMR_ZERO)  stateNext = RUN;
        else                       stateNext = REL_SYS;
      end
      RUN: begin
        if (abortReq) begin
          stateNext = MMCM_RST;
          lossInc   = !lockOk;
        end else begin
          stateNext = RUN;
        end
      end
      default: stateNext = MMCM_RST;
    endcase

    if (stateNext != state)      tmrNext = reloadFor(stateNext);
    else if (tmr != TMR_ZERO)    tmrNext = tmr - TMR_ONE;
    else                         tmrNext = tmr;

    if ((state == WAIT_LOCK) && (stateNext == WAIT_LOCK) && lockOk) stableCntNext = stableCnt + STB_ONE;
    else                                                          stableCntNext = STB_ZERO;
  end

  // State, timers, counters and outputs registered from the next-state decode.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state      <= MMCM_RST;
      tmr        <= TMR_RST_LOAD;
      stableCnt  <= STB_ZERO;
      retryCnt   <= CNT_ZERO;
      lossCnt    <= CNT_ZERO;
      mmcmRstOut <= 1'b1;
      rstTxOut   <= 1'b1;
      rstRxOut   <= 1'b1;
      rstSysOut  <= 1'b1;
      readyOut   <= 1'b0;
    end else begin
      state      <= stateNext;
      tmr        <= tmrNext;
      stableCnt  <= stableCntNext;
      retryCnt   <= retryInc ? satInc(retryCnt) : retryCnt;
      lossCnt    <= lossInc ? satInc(lossCnt) : lossCnt;
      mmcmRstOut <= (stateNext == MMCM_RST);
      rstTxOut   <= (stateNext == MMCM_RST) || (stateNext == WAIT_LOCK);
      rstRxOut   <= !(stateNext inside {REL_RX, REL_SYS, RUN});
      rstSysOut  <= !(stateNext inside {REL_SYS, RUN});
      readyOut   <= (stateNext == RUN);
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with shortened timing parameters; cycle k is the
// interval just after the k-th clkIn rising edge following reset release.
module tb_rst_sequencer;

  logic       clkIn = 1'b0;
  logic       rstNIn, lock0, lock1, swRst;
  logic       mmcmRst, rstTx, rstRx, rstSys, ready;
  logic [1:0] retryCnt, lossCnt;
  logic [8:0] obsVec;
  int         nTests = 0;
  int         nFail  = 0;
  int         cyc    = 0;

  rst_sequencer #(
    .MMCM_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(50),
    .STAGE_GAP_CYCLES   (3),
    .CNT_W              (2)
  ) dut (
    .clkIn         (clkIn),
    .rstNIn        (rstNIn),
    .mmcm0LockedIn (lock0),
    .mmcm1LockedIn (lock1),
    .swRstIn       (swRst),
    .mmcmRstOut    (mmcmRst),
    .rstTxOut      (rstTx),
    .rstRxOut      (rstRx),
    .rstSysOut     (rstSys),
    .readyOut      (ready),
    .retryCntOut   (retryCnt),
    .lockLossCntOut(lossCnt)
  );

  always #5 clkIn = ~clkIn;

  assign obsVec = {mmcmRst, rstTx, rstRx, rstSys, ready, retryCnt, lossCnt};

  task automatic goToCycle(input int k);
    while (cyc < k) begin
      @(posedge clkIn);
      #1;
      cyc++;
    end
  endtask

  task automatic startSeq();
    rstNIn = 1'b0;
    lock0  = 1'b0;
    lock1  = 1'b0;
    swRst  = 1'b0;
    @(posedge clkIn);
    #1;
    rstNIn = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_reset();
    rstNIn = 1'b0;
    lock0  = 1'b0;
    lock1  = 1'b0;
    swRst  = 1'b0;
    repeat (2) @(posedge clkIn);
    #1;
    nTests++;
    if (obsVec !== 9'b1111_0_00_00) begin
      nFail++;
      $display("FAIL reset: got %b expected %b", obsVec, 9'b1111_0_00_00);
    end
  endtask

  task automatic test_power_up();
    logic [8:0] expVec;
    startSeq();
    for (int k = 0; k <= 31; k++) begin
      goToCycle(k);
      expVec = {k < 4, k < 20, k < 23, k < 26, k >= 29, 2'b00, 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL power_up cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
      if (k == 10) begin
        lock0 = 1'b1;
        lock1 = 1'b1;
      end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] expVec;
    logic [1:0] expRetry;
    startSeq();
    for (int k = 0; k <= 225; k++) begin
      goToCycle(k);
      expRetry = ((k / 54) > 3) ? 2'd3 : 2'(k / 54);
      expVec   = {(k % 54) < 4, 1'b1, 1'b1, 1'b1, 1'b0, expRetry, 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL timeout cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
    end
  endtask

  task automatic test_glitch();
    logic [8:0] expVec;
    startSeq();
    for (int k = 0; k <= 37; k++) begin
      goToCycle(k);
      expVec = {k < 4, k < 27, k < 30, k < 33, k >= 36, 2'b00, 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL glitch cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
      if (k == 10) begin
        lock0 = 1'b1;
        lock1 = 1'b1;
      end
      if (k == 16) lock0 = 1'b0;
      if (k == 17) lock0 = 1'b1;
    end
  endtask

  task automatic test_sw_ignored();
    logic [8:0] expVec;
    startSeq();
    for (int k = 0; k <= 6; k++) begin
      goToCycle(k);
      expVec = {k < 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL sw_ignored cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
      if (k == 1) swRst = 1'b1;
      if (k == 2) swRst = 1'b0;
    end
  endtask

  task automatic test_sw_rel_rx();
    logic [8:0] expVec;
    startSeq();
    for (int k = 0; k <= 47; k++) begin
      goToCycle(k);
      expVec = {(k < 4) || (k >= 25 && k < 29),
                (k < 20) || (k >= 25 && k < 37),
                (k < 23) || (k >= 25 && k < 40),
                k < 43, k >= 46, 2'b00, 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL sw_rel_rx cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
      if (k == 10) begin
        lock0 = 1'b1;
        lock1 = 1'b1;
      end
      if (k == 24) swRst = 1'b1;
      if (k == 25) swRst = 1'b0;
    end
  endtask

  task automatic test_lock_loss();
    logic [8:0] expVec;
    startSeq();
    for (int k = 0; k <= 57; k++) begin
      goToCycle(k);
      expVec = {(k < 4) || (k >= 35 && k < 39),
                (k < 20) || (k >= 35 && k < 47),
                (k < 23) || (k >= 35 && k < 50),
                (k < 26) || (k >= 35 && k < 53),
                (k >= 29 && k < 35) || (k >= 56),
                2'b00, (k >= 35) ? 2'b01 : 2'b00};
      nTests++;
      if (obsVec !== expVec) begin
        nFail++;
        $display("FAIL lock_loss cycle %0d: got %b expected %b", k, obsVec, expVec);
      end
      if (k == 10) begin
        lock0 = 1'b1;
        lock1 = 1'b1;
      end
      if (k == 32) lock1 = 1'b0;
      if (k == 36) lock1 = 1'b1;
    end
  endtask

  // Continues from the RUN state left by test_lock_loss (lock-loss count of 1).
  task automatic test_async_reset();
    rstNIn = 1'b0;
    #2;
    nTests++;
    if (obsVec !== 9'b1111_0_00_00) begin
      nFail++;
      $display("FAIL async_reset: got %b expected %b", obsVec, 9'b1111_0_00_00);
    end
  endtask

  initial begin
    rstNIn = 1'b0;
    lock0  = 1'b0;
    lock1  = 1'b0;
    swRst  = 1'b0;
    test_reset();
    test_power_up();
    test_timeout();
    test_glitch();
    test_sw_ignored();
    test_sw_rel_rx();
    test_lock_loss();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
